// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and a
// gate-level counter increment so the controller itself carries no adder.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Wide enough for $clog2(WIDTH+1) at the largest legal WIDTH of 32.
  localparam int unsigned CntWMax = 6;

  // Ripple increment built from XOR/AND so no behavioural '+' is synthesised.
  function automatic logic [CntWMax-1:0] cnt_inc(input logic [CntWMax-1:0] x);
    logic [CntWMax-1:0] r;
    logic               c;
    c = 1'b1;
    for (int i = 0; i < CntWMax; i++) begin
      r[i] = x[i] ^ c;
      c    = x[i] & c;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and result bus of the bit-serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/full_adder_using_nand.sv
// One-bit full adder built only from two-input NAND gates (nine gates).
module full_adder_using_nand (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic Sum,
  output logic Carry
);
  logic n1, n2, n3, x1, n4, n5, n6;

  assign n1    = ~(a & b);
  assign n2    = ~(a & n1);
  assign n3    = ~(b & n1);
  assign x1    = ~(n2 & n3);  // a ^ b
  assign n4    = ~(x1 & c);
  assign n5    = ~(x1 & n4);
  assign n6    = ~(c & n4);
  assign Sum   = ~(n5 & n6);
  assign Carry = ~(n4 & n1);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams WIDTH operand bits LSB first through one
// NAND full-adder cell, closing the carry loop through a register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, s_sr_d, sum_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, cout_q, busy_q, done_q;
  logic             fa_sum, fa_carry;

  full_adder_using_nand u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .c    (c_q),
    .Sum  (fa_sum),
    .Carry(fa_carry)
  );

  always_comb begin
    // New sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
    s_sr_d = (s_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    cnt_d  = CntW'(cnt_inc(CntWMax'(cnt_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            c_q     <= bus.cin;
            s_sr_q  <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          s_sr_q <= s_sr_d;
          c_q    <= fa_carry;
          cnt_q  <= cnt_d;
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= s_sr_d;
            cout_q  <= fa_carry;
          end
        end
        default: begin
          // Unused encoding: fall back to idle without touching the result.
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
